fx_arb: RTL and testbench

//  Two-master arbiter for the fx register bus. Serialises single-byte read/write commands

---
 rtl/fx_arb.sv | 138 +++++++++++++
 tb/tb_fx_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_arb.sv
// Two-master round-robin arbiter for the fx register bus.
// Each command is serialised onto the fx port. Read data is captured RD_LAT cycles after fx_rd.
module fx_arb #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [21:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [21:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    output logic        fx_wr,
    output logic [21:0] fx_waddr,
    output logic [7:0]  fx_data,
    output logic        fx_rd,
    output logic [21:0] fx_raddr,
    input  logic [7:0]  fx_q,
    output logic        fx_busy
);

    // Handshake: a master holds req with a stable command until it sees a one-cycle ack;
    // on the edge that samples ack it may drop req or present the next command.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t      state;
    state_t      state_next;
    logic        gnt;
    logic        last_gnt;
    logic        cmd_we;
    logic [3:0]  cnt;
    logic        any_req;
    logic        sel;
    logic        sel_we;
    logic [21:0] sel_addr;
    logic [7:0]  sel_wdata;

    // On a contest the master that did not win last time gets the grant.
    always_comb begin
        any_req   = m0_req | m1_req;
        sel       = (m0_req & m1_req) ? ~last_gnt : m1_req;
        sel_we    = sel ? m1_we    : m0_we;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;

        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = cmd_we ? DONE : WAIT;
            WAIT:    if (cnt == 4'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            cmd_we   <= 1'b0;
            cnt      <= 4'd0;
            m0_ack   <= 1'b0;
            m0_rdata <= 8'h00;
            m1_ack   <= 1'b0;
            m1_rdata <= 8'h00;
            fx_wr    <= 1'b0;
            fx_waddr <= 22'h0;
            fx_data  <= 8'h00;
            fx_rd    <= 1'b0;
            fx_raddr <= 22'h0;
            fx_busy  <= 1'b0;
        end else begin
            state   <= state_next;
            fx_wr   <= 1'b0;
            fx_rd   <= 1'b0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            fx_busy <= (state_next != IDLE);

            case (state)
                IDLE: begin
                    // Strobes are registered here so they are high exactly while in ISSUE.
                    if (any_req) begin
                        gnt    <= sel;
                        cmd_we <= sel_we;
                        if (sel_we) begin
                            fx_wr    <= 1'b1;
                            fx_waddr <= sel_addr;
                            fx_data  <= sel_wdata;
                        end else begin
                            fx_rd    <= 1'b1;
                            fx_raddr <= sel_addr;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= LAT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (gnt) m1_rdata <= fx_q;
                        else     m0_rdata <= fx_q;
                    end
                end
                DONE: begin
                    last_gnt <= gnt;
                end
                default: ;
            endcase

            if (state_next == DONE) begin
                m0_ack <= ~gnt;
                m1_ack <= gnt;
            end
        end
    end

    strobe_exclusive: assert property (@(posedge clk_sys) !(fx_wr && fx_rd));
    ack_exclusive:    assert property (@(posedge clk_sys) !(m0_ack && m1_ack));

endmodule

// File: tb/tb_fx_arb.sv
// Bench for fx_arb: directed scenarios plus randomized traffic from two masters,
// checked by a scoreboard of expected commands and a transaction-level arbitration model.
module tb_fx_arb;

    localparam int RD_LAT = 2;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [21:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, fx_wr, fx_rd, fx_busy;
    logic [7:0]  m0_rdata, m1_rdata, fx_data;
    logic [21:0] fx_waddr, fx_raddr;
    logic [7:0]  fx_q = '0;

    // Latency-variant instances share one read master and one slave data stream.
    logic        l_req = 1'b0, z1 = 1'b0;
    logic [21:0] l_addr = 22'h001234, z22 = '0;
    logic [7:0]  l_q = '0, z8 = '0;
    logic        l1_m0_ack, l1_m1_ack, l1_fx_wr, l1_fx_rd, l1_fx_busy;
    logic [7:0]  l1_m0_rdata, l1_m1_rdata, l1_fx_data;
    logic [21:0] l1_fx_waddr, l1_fx_raddr;
    logic        l15_m0_ack, l15_m1_ack, l15_fx_wr, l15_fx_rd, l15_fx_busy;
    logic [7:0]  l15_m0_rdata, l15_m1_rdata, l15_fx_data;
    logic [21:0] l15_fx_waddr, l15_fx_raddr;

    always #5 clk_sys = ~clk_sys;

    fx_arb #(.RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .fx_busy(fx_busy)
    );

    fx_arb #(.RD_LAT(1)) u_lat1 (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(l_req), .m0_we(z1), .m0_addr(l_addr), .m0_wdata(z8),
        .m0_ack(l1_m0_ack), .m0_rdata(l1_m0_rdata),
        .m1_req(z1), .m1_we(z1), .m1_addr(z22), .m1_wdata(z8),
        .m1_ack(l1_m1_ack), .m1_rdata(l1_m1_rdata),
        .fx_wr(l1_fx_wr), .fx_waddr(l1_fx_waddr), .fx_data(l1_fx_data),
        .fx_rd(l1_fx_rd), .fx_raddr(l1_fx_raddr), .fx_q(l_q), .fx_busy(l1_fx_busy)
    );

    fx_arb #(.RD_LAT(15)) u_lat15 (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(l_req), .m0_we(z1), .m0_addr(l_addr), .m0_wdata(z8),
        .m0_ack(l15_m0_ack), .m0_rdata(l15_m0_rdata),
        .m1_req(z1), .m1_we(z1), .m1_addr(z22), .m1_wdata(z8),
        .m1_ack(l15_m1_ack), .m1_rdata(l15_m1_rdata),
        .fx_wr(l15_fx_wr), .fx_waddr(l15_fx_waddr), .fx_data(l15_fx_data),
        .fx_rd(l15_fx_rd), .fx_raddr(l15_fx_raddr), .fx_q(l_q), .fx_busy(l15_fx_busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Scoreboard entry: {we, addr[21:0], wdata[7:0], expected rdata[7:0]}
    logic [38:0] m0_q[$];
    logic [38:0] m1_q[$];
    logic [38:0] cmd;

    logic        samp0 = 1'b0, samp1 = 1'b0;
    logic        last_acked = 1'b1;
    logic        st_pend = 1'b0, st_we = 1'b0, st_gnt = 1'b0;
    logic [21:0] st_addr = '0;
    logic [7:0]  st_data = '0;
    int          st_cyc = 0;
    logic [7:0]  m0_rd_model = '0, m1_rd_model = '0;
    logic        sl_pend = 1'b0;
    int          sl_target = 0;
    logic [7:0]  sl_data = '0;
    logic        g;

    function automatic logic [7:0] slave_f(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_master_outs"}, 64'({m0_ack, m0_rdata, m1_ack, m1_rdata, fx_busy}), 64'd0);
        check({tag, "_fx_outs"}, 64'({fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data}), 64'd0);
    endtask

    // Called on a falling edge; returns on the falling edge where ack is seen.
    task automatic drive_cmd(input bit m, input logic we, input logic [21:0] addr,
                             input logic [7:0] wd, input bit drop);
        bit got = 1'b0;
        logic [38:0] e;
        e = {we, addr, wd, (we ? 8'h00 : slave_f(addr))};
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_q.push_back(e);
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_q.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if ((!m && m0_ack) || (m && m1_ack)) begin
                got = 1'b1;
                break;
            end
        end
        check(m ? "m1_ack_within_budget" : "m0_ack_within_budget", 64'(got), 64'd1);
        if (drop || !got) begin
            if (!m) m0_req = 1'b0;
            else    m1_req = 1'b0;
        end
    endtask

    task automatic rand_master(input bit m, input int n);
        logic        we;
        logic [21:0] addr;
        bit          drop;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       addr = 22'h3FFFFF;
                1:       addr = 22'h000000;
                default: addr = 22'($urandom);
            endcase
            drop = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_cmd(m, we, addr, 8'($urandom), drop);
            if (drop) repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end
    endtask

    // Request sampling and reset flush happen on the active edge, as the DUT sees them.
    always @(posedge clk_sys) begin
        cyc++;
        samp0 = m0_req;
        samp1 = m1_req;
        if (rst) begin
            m0_q.delete();
            m1_q.delete();
            st_pend     = 1'b0;
            last_acked  = 1'b1;
            m0_rd_model = 8'h00;
            m1_rd_model = 8'h00;
            sl_pend     = 1'b0;
        end
    end

    // Monitor and slave model.
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (fx_wr || fx_rd) begin
                check("strobe_exclusive", 64'(fx_wr & fx_rd), 64'd0);
                check("strobe_while_busy_txn", 64'(st_pend), 64'd0);
                check("busy_at_strobe", 64'(fx_busy), 64'd1);
                st_pend = 1'b1;
                st_we   = fx_wr;
                st_addr = fx_wr ? fx_waddr : fx_raddr;
                st_data = fx_data;
                st_cyc  = cyc;
                st_gnt  = (samp0 && samp1) ? ~last_acked : samp1;
                if (fx_rd) begin
                    sl_pend   = 1'b1;
                    sl_target = cyc + RD_LAT;
                    sl_data   = slave_f(fx_raddr);
                end
            end
            if (m0_ack || m1_ack) begin
                g = m1_ack;
                check("ack_exclusive", 64'(m0_ack & m1_ack), 64'd0);
                check("ack_has_strobe", 64'(st_pend), 64'd1);
                check("ack_has_cmd", 64'((g ? m1_q.size() : m0_q.size()) != 0), 64'd1);
                if (st_pend && (g ? m1_q.size() : m0_q.size()) != 0) begin
                    cmd = g ? m1_q.pop_front() : m0_q.pop_front();
                    check("grant_order", 64'(g), 64'(st_gnt));
                    check("cmd_type", 64'(st_we), 64'(cmd[38]));
                    check("cmd_addr", 64'(st_addr), 64'(cmd[37:16]));
                    if (cmd[38]) check("cmd_wdata", 64'(st_data), 64'(cmd[15:8]));
                    check("ack_latency", 64'(cyc - st_cyc), 64'(cmd[38] ? 1 : 1 + RD_LAT));
                    check("busy_at_ack", 64'(fx_busy), 64'd1);
                    if (!cmd[38]) begin
                        check("rdata", 64'(g ? m1_rdata : m0_rdata), 64'(cmd[7:0]));
                        if (g) m1_rd_model = cmd[7:0];
                        else   m0_rd_model = cmd[7:0];
                    end
                    check("other_rdata_held", 64'(g ? m0_rdata : m1_rdata),
                          64'(g ? m0_rd_model : m1_rd_model));
                end
                last_acked = g;
                st_pend    = 1'b0;
            end
        end
        // Correct data only in the capture cycle; its complement around it.
        if (sl_pend && cyc > sl_target) sl_pend = 1'b0;
        if (sl_pend) fx_q = (cyc == sl_target) ? sl_data : ~sl_data;
        else         fx_q = 8'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ack1_cyc;
        int ack15_cyc;
        logic [7:0] r1;
        logic [7:0] r15;

        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        check_outputs_zero("reset");

        // Single write from m0, then idle.
        drive_cmd(0, 1'b1, 22'h000123, 8'hA5, 1'b1);
        check("t1_m1_no_ack", 64'(m1_ack), 64'd0);
        @(negedge clk_sys);
        check("t1_busy_low_after", 64'(fx_busy), 64'd0);
        check("t1_wr_low_after", 64'(fx_wr), 64'd0);

        // m1 read at the top address.
        drive_cmd(1, 1'b0, 22'h3FFFFF, 8'h00, 1'b1);
        repeat (2) @(negedge clk_sys);

        // Both masters reading continuously.
        fork
            begin
                for (int i = 0; i < 4; i++) drive_cmd(0, 1'b0, 22'($urandom), 8'h00, i == 3);
            end
            begin
                for (int i = 0; i < 4; i++) drive_cmd(1, 1'b0, 22'($urandom), 8'h00, i == 3);
            end
        join
        repeat (2) @(negedge clk_sys);

        // m0 continuous reads; m1 injects one write mid-stream.
        fork
            begin
                for (int i = 0; i < 4; i++) drive_cmd(0, 1'b0, 22'($urandom), 8'h00, i == 3);
            end
            begin
                repeat (5) @(negedge clk_sys);
                drive_cmd(1, 1'b1, 22'h000ABC, 8'h77, 1'b1);
            end
        join
        repeat (2) @(negedge clk_sys);

        // Reset during WAIT of an m0 read; both re-request afterwards.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h0ABCDE;
        m0_q.push_back({1'b0, 22'h0ABCDE, 8'h00, slave_f(22'h0ABCDE)});
        @(negedge clk_sys);
        check("t5_read_strobe", 64'(fx_rd), 64'd1);
        @(negedge clk_sys);
        check("t5_busy_in_wait", 64'(fx_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk_sys);
        check_outputs_zero("t5_after_rst");
        rst = 1'b0;
        fork
            drive_cmd(0, 1'b0, 22'h0ABCDE, 8'h00, 1'b1);
            drive_cmd(1, 1'b1, 22'h155555, 8'h3C, 1'b1);
        join
        repeat (3) @(negedge clk_sys);

        // Randomized traffic from both masters.
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        repeat (4) @(negedge clk_sys);

        check("m0_queue_drained", 64'(m0_q.size()), 64'd0);
        check("m1_queue_drained", 64'(m1_q.size()), 64'd0);
        check("no_pending_strobe", 64'(st_pend), 64'd0);

        // RD_LAT=1 and RD_LAT=15 instances: slave data is 0x10 + cycle index.
        ack1_cyc = -1; ack15_cyc = -1; r1 = '0; r15 = '0;
        l_req = 1'b1;
        l_q = 8'h10;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk_sys);
            if (l1_m0_ack && ack1_cyc < 0) begin ack1_cyc = t; r1 = l1_m0_rdata; end
            if (l15_m0_ack && ack15_cyc < 0) begin ack15_cyc = t; r15 = l15_m0_rdata; end
            l_q = 8'(8'h10 + t);
        end
        l_req = 1'b0;
        check("lat1_ack_cycle", 64'(ack1_cyc), 64'd3);
        check("lat1_rdata", 64'(r1), 64'h12);
        check("lat15_ack_cycle", 64'(ack15_cyc), 64'd17);
        check("lat15_rdata", 64'(r15), 64'h20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
